// File: rtl/host_cmd_fifo_pkg.sv
// host_cmd_fifo_pkg: shared read-FSM states, default geometry and active-low flag encodings.
package host_cmd_fifo_pkg;
  typedef enum logic {RD_IDLE = 1'b0, RD_ACTIVE = 1'b1} rd_state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH_LOG2 = 4;
  localparam logic FIFO_EMPTY = 1'b0;
  localparam logic FIFO_NOT_EMPTY = 1'b1;
  localparam logic STROBE_ASSERTED = 1'b0;
endpackage

// File: rtl/host_cmd_fifo_strobe_sync.sv
// strobe_sync: multi-flop synchronizer for an idle-high async strobe with rise/fall pulses.
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES:0] r_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '1;
    else r_sync <= {r_sync[SYNC_STAGES-1:0], i_async};
  // the extra top flop is the previous synchronized value for edge detection
  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_sync[SYNC_STAGES];
endmodule

// File: rtl/host_cmd_fifo.sv
// host_cmd_fifo: host-to-display command FIFO with IDT7200-style read side.
// Define HOST_CMD_FIFO_LEVEL_EN to add the level and host_nhf outputs.
module host_cmd_fifo
  import host_cmd_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      host_data_in,
  input  logic                  host_nwr_in,
  output logic                  host_nff,
  output logic [WIDTH-1:0]      disp_cmd_out,
  output logic                  disp_nef,
  input  logic                  disp_cmd_rd,
  output logic                  ovf,
  output logic                  udf
`ifdef HOST_CMD_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  host_nhf
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr, r_rptr;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_dpipe;
  logic [WIDTH-1:0] r_cap;
  rd_state_t r_state, w_next;
  logic r_pend, w_pend_next;
  logic w_sync, w_rise, w_empty, w_full, w_push, w_pop, w_load, w_udf_set;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk),
    .rst(rst),
    .i_async(host_nwr_in),
    .o_sync(w_sync),
    .o_rise(w_rise),
    .o_fall()
  );

  assign w_empty = r_wptr == r_rptr;
  assign w_full = (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]) && (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]);
  assign w_push = w_rise & ~w_full;

  // data pipe has the same depth as the strobe synchronizer so the capture sees matching samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dpipe <= '0;
      r_cap <= '0;
    end else begin
      r_dpipe <= {r_dpipe[SYNC_STAGES-2:0], host_data_in};
      if (w_sync == STROBE_ASSERTED) r_cap <= r_dpipe[SYNC_STAGES-1];
    end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= r_cap;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= RD_IDLE;
      r_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend <= w_pend_next;
    end

  always_comb begin
    w_next = r_state;
    w_pend_next = r_pend;
    w_load = 1'b0;
    w_udf_set = 1'b0;
    w_pop = 1'b0;
    if (r_state == RD_IDLE) begin
      if (disp_cmd_rd == STROBE_ASSERTED) begin
        w_next = RD_ACTIVE;
        w_load = ~w_empty;
        w_udf_set = w_empty;
        w_pend_next = ~w_empty;
      end
    end else if (disp_cmd_rd != STROBE_ASSERTED) begin
      w_next = RD_IDLE;
      w_pop = r_pend;
      w_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      disp_cmd_out <= '0;
      disp_nef <= FIFO_EMPTY;
      host_nff <= 1'b1;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      if (w_load) disp_cmd_out <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
      ovf <= ovf | (w_rise & w_full);
      udf <= udf | w_udf_set;
      disp_nef <= w_empty ? FIFO_EMPTY : FIFO_NOT_EMPTY;
      host_nff <= ~w_full;
    end

`ifdef HOST_CMD_FIFO_LEVEL_EN
  localparam logic [DEPTH_LOG2:0] HALF = PTR_ONE << (DEPTH_LOG2 - 1);
  logic [DEPTH_LOG2:0] w_diff;
  assign w_diff = r_wptr - r_rptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level <= '0;
      host_nhf <= 1'b1;
    end else begin
      level <= w_diff;
      host_nhf <= ~(w_diff >= HALF);
    end
`endif
endmodule

// File: tb/tb_host_cmd_fifo.sv
// tb_host_cmd_fifo: table-driven, directed and randomized checks against a queue model.
module tb_host_cmd_fifo;
  localparam int SS = 2;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] host_data_in = 8'h00;
  logic host_nwr_in = 1'b1;
  logic disp_cmd_rd = 1'b1;
  logic host_nff, disp_nef, ovf, udf;
  logic [7:0] disp_cmd_out;
`ifdef HOST_CMD_FIFO_LEVEL_EN
  logic [4:0] level;
  logic host_nhf;
`endif

  host_cmd_fifo #(.WIDTH(8), .DEPTH_LOG2(4), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .rst(rst),
    .host_data_in(host_data_in),
    .host_nwr_in(host_nwr_in),
    .host_nff(host_nff),
    .disp_cmd_out(disp_cmd_out),
    .disp_nef(disp_nef),
    .disp_cmd_rd(disp_cmd_rd),
    .ovf(ovf),
    .udf(udf)
`ifdef HOST_CMD_FIFO_LEVEL_EN
    ,
    .level(level),
    .host_nhf(host_nhf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic mdl_ovf = 1'b0;
  logic mdl_udf = 1'b0;
  logic [7:0] mdl_dout = 8'h00;

  typedef struct {
    bit wr;
    logic [7:0] data;
    int hold;
    logic [7:0] dout;
    logic nef, nff, ovf, udf;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " nef"}, 32'(disp_nef), 32'(q.size() != 0));
    chk({tag, " nff"}, 32'(host_nff), 32'(q.size() != DEPTH));
    chk({tag, " ovf"}, 32'(ovf), 32'(mdl_ovf));
    chk({tag, " udf"}, 32'(udf), 32'(mdl_udf));
    chk({tag, " dout"}, 32'(disp_cmd_out), 32'(mdl_dout));
`ifdef HOST_CMD_FIFO_LEVEL_EN
    chk({tag, " level"}, 32'(level), 32'(q.size()));
    chk({tag, " nhf"}, 32'(host_nhf), 32'(q.size() < DEPTH / 2));
`endif
  endtask

  task automatic host_write(input logic [7:0] d, output int lat);
    @(negedge clk);
    host_data_in = d;
    host_nwr_in = 1'b0;
    repeat (3) @(negedge clk);
    host_nwr_in = 1'b1;
    host_data_in = ~d;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (disp_nef && lat == 0) lat = i;
    end
    if (q.size() < DEPTH) q.push_back(d);
    else mdl_ovf = 1'b1;
  endtask

  task automatic disp_read(input int hold);
    logic [7:0] exp;
    bit had;
    had = q.size() != 0;
    exp = had ? q[0] : mdl_dout;
    @(negedge clk);
    disp_cmd_rd = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("read data", 32'(disp_cmd_out), 32'(exp));
    end
    if (!had) mdl_udf = 1'b1;
    mdl_dout = exp;
    disp_cmd_rd = 1'b1;
    @(negedge clk);
    chk("nef before release settles", 32'(disp_nef), 32'(had));
    if (had) void'(q.pop_front());
    @(negedge clk);
    chk_state("after read");
  endtask

  // host push completion and read release land on the same clock edge
  task automatic aligned_op(input logic [7:0] d);
    logic [7:0] exp;
    exp = q[0];
    @(negedge clk);
    host_data_in = d;
    host_nwr_in = 1'b0;
    disp_cmd_rd = 1'b0;
    @(negedge clk);
    chk("aligned data", 32'(disp_cmd_out), 32'(exp));
    @(negedge clk);
    @(negedge clk);
    host_nwr_in = 1'b1;
    host_data_in = ~d;
    @(negedge clk);
    @(negedge clk);
    disp_cmd_rd = 1'b1;
    @(negedge clk);
    chk("aligned nef", 32'(disp_nef), 32'd1);
    @(negedge clk);
    void'(q.pop_front());
    q.push_back(d);
    mdl_dout = exp;
    chk_state("aligned");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    tbl[0] = '{1'b1, 8'hA5, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 6, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 2, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h3C, 0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'hC3, 0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 3, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_state("reset");

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) host_write(tbl[i].data, lat);
      else disp_read(tbl[i].hold);
      if (i == 0) chk("push to nef latency", 32'(lat), 32'(SS + 2));
      chk($sformatf("row%0d dout", i), 32'(disp_cmd_out), 32'(tbl[i].dout));
      chk($sformatf("row%0d nef", i), 32'(disp_nef), 32'(tbl[i].nef));
      chk($sformatf("row%0d nff", i), 32'(host_nff), 32'(tbl[i].nff));
      chk($sformatf("row%0d ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      chk($sformatf("row%0d udf", i), 32'(udf), 32'(tbl[i].udf));
    end

    for (int i = 0; i < 16; i++) begin
      host_write(8'(i), lat);
      chk_state("fill");
    end
    chk("full flag", 32'(host_nff), 32'd0);
    host_write(8'hFF, lat);
    chk("overflow", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain order", 32'(q[0]), 32'(i));
      disp_read(2);
    end
    disp_read(3);
    chk("underflow keeps dout", 32'(disp_cmd_out), 32'h0F);

    for (int i = 0; i < 5; i++) host_write(8'($urandom), lat);
    for (int i = 0; i < 40; i++) aligned_op(8'($urandom));
    chk("aligned occupancy", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) disp_read(1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) host_write(8'($urandom), lat);
      else disp_read(int'($urandom_range(4, 1)));
      chk_state("random");
    end

    for (int i = 0; i < 3 - q.size(); i++) host_write(8'($urandom), lat);
    while (q.size() > 3) disp_read(1);
    @(negedge clk);
    disp_cmd_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    mdl_ovf = 1'b0;
    mdl_udf = 1'b0;
    mdl_dout = 8'h00;
    chk_state("reset mid-read");
    @(negedge clk);
    rst = 1'b0;
    disp_cmd_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk_state("post reset release");
    host_write(8'h77, lat);
    disp_read(2);
    chk("no phantom pop", 32'(mdl_dout), 32'h77);
    for (int i = 0; i < 8; i++) host_write(8'(8'h40 + i), lat);
    chk_state("eight entries");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
